// File: rtl/sumatoria_pipe.sv
// sumatoria_pipe: pipelined ones-count of an oversampled word, plus a windowed accumulator.
// Each SAMPLES*OSF-bit word is split into OSF-bit groups. The groups are popcounted, then
// summed through a registered pairwise adder tree of L = 1+$clog2(SAMPLES) register levels.
// ACC_FRAMES consecutive word sums are then totalled into acc.
// Optional feature: define SUMATORIA_THERMO_CHECK_EN to flag groups that are not LSB-filled
// thermometer codes on the bubble output. When it is undefined, bubble is tied low.
module sumatoria_pipe #(
    parameter int SAMPLES    = 2,
    parameter int OSF        = 8,
    parameter int ACC_FRAMES = 4,
    localparam int SW = $clog2(SAMPLES*OSF) + 1,
    localparam int AW = $clog2(SAMPLES*OSF*ACC_FRAMES) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [SAMPLES*OSF-1:0] in_data,
    output logic                   sum_valid,
    output logic [SW-1:0]          sum,
    output logic                   acc_valid,
    output logic [AW-1:0]          acc,
    output logic                   bubble
);
    localparam int LV   = $clog2(SAMPLES);          // adder tree levels above the leaves
    localparam int NP   = 1 << LV;                  // leaf count padded to a power of two
    localparam int CW   = $clog2(OSF) + 1;          // per-group popcount width
    localparam int TW   = CW + LV;                  // tree node width, wide enough for any level
    localparam int CNTW = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(ACC_FRAMES - 1);

    function automatic logic [TW-1:0] popcount(input logic [OSF-1:0] g);
        logic [TW-1:0] c;
        c = '0;
        for (int b = 0; b < OSF; b++) c = c + TW'(g[b]);
        return c;
    endfunction

    // Tree stored heap-style: node i has children 2i and 2i+1. Leaves sit at NP..2NP-1.
    logic [TW-1:0] r_node [1:2*NP-1];
    logic [LV:0]   r_vld;

    // valid bit travels one register level per cycle alongside the data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= in_valid;
            for (int i = 1; i <= LV; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_leaf
            if (gi < SAMPLES) begin : g_real
                // register the popcount of one group whenever a word arrives
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)         r_node[NP+gi] <= '0;
                    else if (in_valid) r_node[NP+gi] <= popcount(in_data[gi*OSF +: OSF]);
                end
            end else begin : g_pad
                // padding leaf: a constant zero so that odd group counts add cleanly
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) r_node[NP+gi] <= '0;
                    else       r_node[NP+gi] <= '0;
                end
            end
        end

        for (gi = 1; gi < NP; gi++) begin : g_tree
            localparam int H = LV - $clog2(gi + 1) + 1;   // height of this node above the leaves
            // pairwise sum; the node loads only when its input level holds a valid word
            always_ff @(posedge clk or posedge reset) begin
                if (reset)             r_node[gi] <= '0;
                else if (r_vld[H-1])   r_node[gi] <= r_node[2*gi] + r_node[2*gi+1];
            end
        end
    endgenerate

    assign sum_valid = r_vld[LV];
    assign sum       = r_node[1][SW-1:0];

`ifdef SUMATORIA_THERMO_CHECK_EN
    // A group g is a valid LSB-filled thermometer code exactly when g & (g+1) == 0.
    function automatic logic not_thermo(input logic [OSF-1:0] g);
        logic [OSF-1:0] g1;
        g1 = g + OSF'(1);
        return (g & g1) != '0;
    endfunction

    logic        w_bad;
    logic [LV:0] r_bub;

    // OR of per-group thermometer failures for the incoming word
    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < SAMPLES; k++) w_bad = w_bad | not_thermo(in_data[k*OSF +: OSF]);
    end

    // flag rides the pipeline in step with its word and holds between words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bub <= '0;
        end else begin
            if (in_valid) r_bub[0] <= w_bad;
            for (int i = 1; i <= LV; i++)
                if (r_vld[i-1]) r_bub[i] <= r_bub[i-1];
        end
    end

    assign bubble = r_bub[LV];
`else
    assign bubble = 1'b0;
`endif

    logic [AW-1:0]   r_run;
    logic [CNTW-1:0] r_cnt;
    logic [AW-1:0]   r_acc;
    logic            r_acc_valid;
    logic [AW-1:0]   w_sum_ext;
    logic [AW-1:0]   w_base;
    logic [CNTW-1:0] w_cnt_base;

    // clear discards the open window first, so a word arriving with it opens the next window
    assign w_sum_ext  = AW'(sum);
    assign w_base     = clear ? '0 : r_run;
    assign w_cnt_base = clear ? '0 : r_cnt;

    // window accumulation: the last frame of a window publishes the total and restarts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= 1'b0;
            if (sum_valid) begin
                if (w_cnt_base == LAST) begin
                    r_acc       <= w_base + w_sum_ext;
                    r_acc_valid <= 1'b1;
                    r_run       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_run <= w_base + w_sum_ext;
                    r_cnt <= w_cnt_base + CNTW'(1);
                end
            end else if (clear) begin
                r_run <= '0;
                r_cnt <= '0;
            end
        end
    end

    assign acc_valid = r_acc_valid;
    assign acc       = r_acc;

endmodule

// File: tb/tb_sumatoria_pipe.sv
// Testbench for sumatoria_pipe (SAMPLES=2, OSF=8, ACC_FRAMES=4).
// It uses a word-level reference model: a transport delay line and a window queue.
`timescale 1ns/1ps
module tb_sumatoria_pipe;
    localparam int SAMPLES    = 2;
    localparam int OSF        = 8;
    localparam int ACC_FRAMES = 4;
    localparam int SW         = 5;
    localparam int AW         = 7;
    localparam int L          = 2;

`ifdef SUMATORIA_THERMO_CHECK_EN
    localparam bit THERMO_EN = 1'b1;
`else
    localparam bit THERMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic [15:0]   in_data;
    logic          sum_valid;
    logic [SW-1:0] sum;
    logic          acc_valid;
    logic [AW-1:0] acc;
    logic          bubble;

    sumatoria_pipe #(.SAMPLES(SAMPLES), .OSF(OSF), .ACC_FRAMES(ACC_FRAMES)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .sum_valid(sum_valid), .sum(sum), .acc_valid(acc_valid), .acc(acc), .bubble(bubble)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_sum  = 0;
    int n_acc  = 0;
    int last_acc = 0;

    typedef struct { bit v; logic [15:0] d; } word_t;
    word_t       dl[$];
    int unsigned win[$];
    bit          e_sv, e_av, e_bub;
    int          e_sum, e_acc;

    typedef struct { logic [15:0] d; int exp_sum; bit bub; } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // A group is legal when it equals 2^(its ones count) - 1.
    function automatic bit is_bad(input logic [15:0] d);
        int g, c;
        for (int k = 0; k < SAMPLES; k++) begin
            g = int'(d[k*OSF +: OSF]);
            c = $countones(d[k*OSF +: OSF]);
            if (g != ((1 << c) - 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        word_t z;
        z.v = 1'b0; z.d = '0;
        dl.delete();
        for (int i = 0; i < L - 1; i++) dl.push_back(z);
        win.delete();
        e_sv = 0; e_av = 0; e_bub = 0; e_sum = 0; e_acc = 0;
    endtask

    // One clock edge of the reference: the window consumes the strobe visible during the ending
    // cycle, then the delay line advances.
    task automatic model_edge(input bit v, input logic [15:0] d, input bit clr);
        word_t w, o;
        int tot;
        e_av = 1'b0;
        if (clr) win.delete();
        if (e_sv) begin
            win.push_back(e_sum);
            if (win.size() == ACC_FRAMES) begin
                tot = 0;
                foreach (win[i]) tot += win[i];
                e_acc = tot;
                e_av  = 1'b1;
                win.delete();
            end
        end
        w.v = v; w.d = d;
        dl.push_back(w);
        o = dl.pop_front();
        e_sv = o.v;
        if (o.v) begin
            e_sum = $countones(o.d);
            e_bub = THERMO_EN && is_bad(o.d);
        end
    endtask

    task automatic cyc(input bit v, input logic [15:0] d, input bit clr);
        in_valid = v; in_data = d; clear = clr;
        @(posedge clk);
        model_edge(v, d, clr);
        #1;
        chk("sum_valid", sum_valid, e_sv);
        chk("sum", sum, e_sum);
        chk("bubble", bubble, e_bub);
        chk("acc_valid", acc_valid, e_av);
        chk("acc", acc, e_acc);
        if (sum_valid) begin
            n_sum++;
            $display("sum  t=%0t sum=%0d bubble=%0b", $time, sum, bubble);
        end
        if (acc_valid) begin
            n_acc++;
            last_acc = acc;
            $display("acc  t=%0t acc=%0d", $time, acc);
        end
    endtask

    // Asserts reset between edges, checks outputs collapse at once, and releases after one edge.
    task automatic async_reset();
        in_valid = 1'b0; clear = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_bubble", bubble, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int s0, a0;
        bit v, c;
        logic [15:0] d;

        tbl[0] = '{16'h00FF, 8, 1'b0};
        tbl[1] = '{16'hFFFF, 16, 1'b0};
        tbl[2] = '{16'h0000, 0, 1'b0};
        tbl[3] = '{16'h0F07, 7, 1'b0};
        tbl[4] = '{16'h0001, 1, 1'b0};
        tbl[5] = '{16'h0005, 2, 1'b1};
        tbl[6] = '{16'h7F03, 9, 1'b0};
        tbl[7] = '{16'h8000, 1, 1'b1};
        tbl[8] = '{16'h0180, 2, 1'b1};
        tbl[9] = '{16'h3F1F, 11, 1'b0};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_sum_valid", sum_valid, 0);
        chk("init_sum", sum, 0);
        chk("init_acc_valid", acc_valid, 0);
        chk("init_acc", acc, 0);
        chk("init_bubble", bubble, 0);
        reset = 1'b0;
        repeat (3) cyc(0, '0, 0);

        // Reset arrives mid-window with words still in flight; no strobe may appear afterwards.
        cyc(1, 16'hFFFF, 0); cyc(1, 16'h00FF, 0); cyc(1, 16'h0F07, 0);
        async_reset();
        s0 = n_sum; a0 = n_acc;
        repeat (6) cyc(0, '0, 0);
        chk("t1_no_stale_sum", n_sum - s0, 0);
        chk("t1_no_stale_acc", n_acc - a0, 0);

        // A single word yields one strobe exactly L cycles later, and sum holds afterwards.
        async_reset();
        cyc(1, 16'h00FF, 0); chk("t2_sv_early", sum_valid, 0);
        cyc(0, '0, 0);       chk("t2_sv", sum_valid, 1); chk("t2_sum", sum, 8);
        cyc(0, '0, 0);       chk("t2_sv_after", sum_valid, 0); chk("t2_hold", sum, 8);

        // Back-to-back words give consecutive sums, and acc fires one cycle after the fourth.
        async_reset();
        cyc(1, 16'hFFFF, 0);
        cyc(1, 16'h0000, 0); chk("t3_s16", sum, 16);
        cyc(1, 16'h0F07, 0); chk("t3_s0", sum, 0);
        cyc(1, 16'h0001, 0); chk("t3_s7", sum, 7);
        cyc(0, '0, 0);       chk("t3_s1", sum, 1); chk("t3_av_early", acc_valid, 0);
        cyc(0, '0, 0);       chk("t3_av", acc_valid, 1); chk("t3_acc", acc, 24);
        cyc(0, '0, 0);       chk("t3_av_pulse", acc_valid, 0);

        // The same words separated by idle gaps produce the same results and no extra strobes.
        async_reset();
        s0 = n_sum; a0 = n_acc;
        cyc(1, 16'hFFFF, 0); repeat (3) cyc(0, '0, 0);
        cyc(1, 16'h0000, 0); repeat (3) cyc(0, '0, 0);
        cyc(1, 16'h0F07, 0); repeat (3) cyc(0, '0, 0);
        cyc(1, 16'h0001, 0); repeat (3) cyc(0, '0, 0);
        chk("t4_sum_count", n_sum - s0, 4);
        chk("t4_acc_count", n_acc - a0, 1);
        chk("t4_acc", last_acc, 24);

        // clear drops a partial window.
        async_reset();
        a0 = n_acc;
        cyc(1, 16'hFFFF, 0); cyc(1, 16'hFFFF, 0);
        cyc(0, '0, 0); cyc(0, '0, 0);
        cyc(0, '0, 1);
        repeat (4) cyc(1, 16'h0003, 0);
        repeat (3) cyc(0, '0, 0);
        chk("t5_acc_count", n_acc - a0, 1);
        chk("t5_acc", last_acc, 8);
        // A clear that coincides with a strobe keeps that word as frame 1 of the new window.
        a0 = n_acc;
        cyc(1, 16'h0003, 0); cyc(1, 16'h0003, 0); cyc(1, 16'h0003, 0);
        cyc(0, '0, 0);
        cyc(0, '0, 1);
        repeat (3) cyc(1, 16'h0001, 0);
        repeat (3) cyc(0, '0, 0);
        chk("t5b_acc_count", n_acc - a0, 1);
        chk("t5b_acc", last_acc, 5);

        // Table of isolated words against hand-computed counts and thermometer flags.
        async_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1, tbl[i].d, 0);
            cyc(0, '0, 0);
            chk($sformatf("tbl%0d_sum", i), sum, tbl[i].exp_sum);
            chk($sformatf("tbl%0d_bubble", i), bubble, THERMO_EN & tbl[i].bub);
        end

        // Randomized traffic against the reference model, with one reset midway.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            v = ($urandom_range(0, 9) < 6);
            c = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) begin
                d = 16'($urandom);
            end else begin
                d[7:0]  = 8'((1 << $urandom_range(0, 8)) - 1);
                d[15:8] = 8'((1 << $urandom_range(0, 8)) - 1);
            end
            cyc(v, d, c);
        end
        repeat (4) cyc(0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
